// File: rtl/riscv_pkg.sv
// Shared encodings and stage control words for the RV32I control pipeline.
package riscv_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned ALUC_W = 3;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } res_src_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_e;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic [ALUC_W-1:0] alu_control;
    logic              alu_src;
    logic [2:0]        funct3;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
  } ctrl_e_t;

  typedef struct packed {
    logic             reg_write;
    logic [1:0]       result_src;
    logic             mem_write;
    logic [REG_W-1:0] rd;
  } ctrl_m_t;

  typedef struct packed {
    logic             reg_write;
    logic [1:0]       result_src;
    logic [REG_W-1:0] rd;
  } ctrl_w_t;

  // Branch condition selected by funct3; unused encodings never take.
  function automatic logic branch_cond(input logic [2:0] f3, input logic zero,
                                       input logic lt, input logic ltu);
    case (f3)
      F3_BEQ:  branch_cond = zero;
      F3_BNE:  branch_cond = !zero;
      F3_BLT:  branch_cond = lt;
      F3_BGE:  branch_cond = !lt;
      F3_BLTU: branch_cond = ltu;
      F3_BGEU: branch_cond = !ltu;
      default: branch_cond = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_pipe_if.sv
// Decoder/datapath <-> control pipeline signal bundle.
interface control_pipe_if
  import riscv_pkg::*;
#(
  parameter int unsigned REGW  = REG_W,
  parameter int unsigned ALUCW = ALUC_W
);
  logic             RegWriteD;
  logic [1:0]       ResultSrcD;
  logic             MemWriteD;
  logic             JumpD;
  logic             BranchD;
  logic [ALUCW-1:0] ALUControlD;
  logic             ALUSrcD;
  logic [2:0]       funct3D;
  logic [REGW-1:0]  Rs1D;
  logic [REGW-1:0]  Rs2D;
  logic [REGW-1:0]  RdD;
  logic             ZeroE;
  logic             LtE;
  logic             LtuE;
  logic [ALUCW-1:0] ALUControlE;
  logic             ALUSrcE;
  logic             PCSrcE;
  logic             MemWriteM;
  logic [1:0]       ResultSrcW;
  logic             RegWriteW;
  logic [REGW-1:0]  RdW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;

  modport master (
    output RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
           funct3D, Rs1D, Rs2D, RdD, ZeroE, LtE, LtuE,
    input  ALUControlE, ALUSrcE, PCSrcE, MemWriteM, ResultSrcW, RegWriteW, RdW,
           ForwardAE, ForwardBE, StallF, StallD, FlushD
  );

  modport slave (
    input  RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
           funct3D, Rs1D, Rs2D, RdD, ZeroE, LtE, LtuE,
    output ALUControlE, ALUSrcE, PCSrcE, MemWriteM, ResultSrcW, RegWriteW, RdW,
           ForwardAE, ForwardBE, StallF, StallD, FlushD
  );
endinterface

// File: rtl/control_pipe_hazard.sv
// Combinational hazard detection: load-use stall, flushes and forward selects.
module hazard_unit
  import riscv_pkg::*;
(
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic [1:0]       result_src_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_w,
  input  logic             pc_src_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e
);

  // M result is newer than W, so it wins; x0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                         input logic [REG_W-1:0] rdm, input logic rwm,
                                         input logic [REG_W-1:0] rdw, input logic rww);
    if (rs != '0 && rs == rdm && rwm)      fwd_sel = FWD_M;
    else if (rs != '0 && rs == rdw && rww) fwd_sel = FWD_W;
    else                                   fwd_sel = FWD_RF;
  endfunction

  logic lw_stall;

  // Stall on a load in E feeding either D source; flush on a taken branch/jump.
  always_comb begin
    lw_stall    = (result_src_e == RES_LOAD) && (rd_e != '0) &&
                  ((rs1_d == rd_e) || (rs2_d == rd_e));
    stall_f     = lw_stall;
    stall_d     = lw_stall;
    flush_d     = pc_src_e;
    flush_e     = lw_stall | pc_src_e;
    forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
  end

endmodule

// File: rtl/control_pipe.sv
// Control pipeline: carries the decoded control word D->E->M->W, resolves branches in E.
module control_pipe
  import riscv_pkg::*;
#(
  parameter int unsigned REGW  = REG_W,
  parameter int unsigned ALUCW = ALUC_W
) (
  input logic           clk,
  input logic           reset,
  control_pipe_if.slave bus
);

  ctrl_e_t          d_word;
  ctrl_e_t          e_q;
  ctrl_m_t          m_q;
  ctrl_w_t          w_q;
  logic             pc_src_e;
  logic             flush_e;
  logic             stall_d;
  logic [ALUCW-1:0] alu_control_e;
  logic [REGW-1:0]  rd_w;

  assign d_word = '{reg_write:   bus.RegWriteD,
                    result_src:  bus.ResultSrcD,
                    mem_write:   bus.MemWriteD,
                    jump:        bus.JumpD,
                    branch:      bus.BranchD,
                    alu_control: bus.ALUControlD,
                    alu_src:     bus.ALUSrcD,
                    funct3:      bus.funct3D,
                    rs1:         bus.Rs1D,
                    rs2:         bus.Rs2D,
                    rd:          bus.RdD};

  assign pc_src_e = (e_q.branch & branch_cond(e_q.funct3, bus.ZeroE, bus.LtE, bus.LtuE))
                  | e_q.jump;

  hazard_unit u_hazard (
    .rs1_d        (bus.Rs1D),
    .rs2_d        (bus.Rs2D),
    .rs1_e        (e_q.rs1),
    .rs2_e        (e_q.rs2),
    .rd_e         (e_q.rd),
    .result_src_e (e_q.result_src),
    .rd_m         (m_q.rd),
    .reg_write_m  (m_q.reg_write),
    .rd_w         (w_q.rd),
    .reg_write_w  (w_q.reg_write),
    .pc_src_e     (pc_src_e),
    .stall_f      (bus.StallF),
    .stall_d      (stall_d),
    .flush_d      (bus.FlushD),
    .flush_e      (flush_e),
    .forward_a_e  (bus.ForwardAE),
    .forward_b_e  (bus.ForwardBE)
  );

  // Pipeline registers: E takes a bubble on flush, M and W always advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= flush_e ? '0 : d_word;
      m_q <= '{reg_write: e_q.reg_write, result_src: e_q.result_src,
               mem_write: e_q.mem_write, rd: e_q.rd};
      w_q <= '{reg_write: m_q.reg_write, result_src: m_q.result_src, rd: m_q.rd};
    end
  end

  assign alu_control_e = e_q.alu_control;
  assign rd_w          = w_q.rd;

  assign bus.ALUControlE = alu_control_e;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.PCSrcE      = pc_src_e;
  assign bus.MemWriteM   = m_q.mem_write;
  assign bus.ResultSrcW  = w_q.result_src;
  assign bus.RegWriteW   = w_q.reg_write;
  assign bus.RdW         = rd_w;
  assign bus.StallD      = stall_d;

  // A load in E is never a branch or jump, so both hazards cannot coincide.
  assert property (@(posedge clk) disable iff (!reset) !(stall_d && pc_src_e));

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe: expected W/M words queued at issue, popped at output.
module tb_control_pipe;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       j;
    logic       b;
    logic [2:0] aluc;
    logic       as;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } d_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic [4:0] rd;
  } w_t;

  localparam d_t NOP = '0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   sb_on = 1'b0;
  w_t   wq[$];
  logic mq[$];

  control_pipe_if #(.REGW(5), .ALUCW(3)) bus ();

  control_pipe #(.REGW(5), .ALUCW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  // Scoreboard: W word is due 3 cycles after issue, M store enable 2 cycles after.
  always @(negedge clk) begin
    if (sb_on) begin
      if (wq.size() >= 4) begin
        w_t e;
        w_t got;
        e   = wq.pop_front();
        got = '{bus.RegWriteW, bus.ResultSrcW, bus.RdW};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL sb_w got rw=%b rs=%b rd=%0d exp rw=%b rs=%b rd=%0d @%0t",
                   got.rw, got.rs, got.rd, e.rw, e.rs, e.rd, $time);
        end
      end
      if (mq.size() >= 3) begin
        logic em;
        em = mq.pop_front();
        checks++;
        if (bus.MemWriteM !== em) begin
          failures++;
          $display("FAIL sb_memwrite_m got=%b exp=%b @%0t", bus.MemWriteM, em, $time);
        end
      end
    end
  end

  task automatic put(input d_t d, input logic [2:0] f);
    bus.RegWriteD   = d.rw;
    bus.ResultSrcD  = d.rs;
    bus.MemWriteD   = d.mw;
    bus.JumpD       = d.j;
    bus.BranchD     = d.b;
    bus.ALUControlD = d.aluc;
    bus.ALUSrcD     = d.as;
    bus.funct3D     = d.f3;
    bus.Rs1D        = d.rs1;
    bus.Rs2D        = d.rs2;
    bus.RdD         = d.rd;
    bus.ZeroE       = f[2];
    bus.LtE         = f[1];
    bus.LtuE        = f[0];
  endtask

  // One issue slot: present d after the edge, queue what W/M must show, stop at negedge.
  task automatic drive(input d_t d, input logic [2:0] f, input bit bubble);
    @(posedge clk);
    #1;
    put(d, f);
    if (bubble) begin
      wq.push_back('0);
      mq.push_back(1'b0);
    end else begin
      wq.push_back('{d.rw, d.rs, d.rd});
      mq.push_back(d.mw);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    d_t d;
    @(posedge clk);
    #1;
    sb_on = 1'b0;
    wq.delete();
    mq.delete();
    reset = 1'b0;
    d = NOP; d.rw = 1'b1; d.rd = 5'd5;
    put(d, 3'b000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.RegWriteW !== 1'b0) begin failures++; $display("FAIL reset_regwrite_w got=%b exp=0", bus.RegWriteW); end
      checks++; if (bus.RdW !== 5'd0) begin failures++; $display("FAIL reset_rd_w got=%0d exp=0", bus.RdW); end
      checks++; if (bus.PCSrcE !== 1'b0) begin failures++; $display("FAIL reset_pcsrc_e got=%b exp=0", bus.PCSrcE); end
      checks++; if ({bus.StallF, bus.StallD, bus.FlushD} !== 3'b000) begin failures++; $display("FAIL reset_stall_flush got=%b exp=000", {bus.StallF, bus.StallD, bus.FlushD}); end
      checks++; if (bus.MemWriteM !== 1'b0) begin failures++; $display("FAIL reset_memwrite_m got=%b exp=0", bus.MemWriteM); end
    end
    reset = 1'b1;
    put(NOP, 3'b000);
    repeat (3) wq.push_back('0);
    repeat (2) mq.push_back(1'b0);
    sb_on = 1'b1;
  endtask

  task automatic test_latency;
    d_t d;
    d = NOP; d.rw = 1'b1; d.rd = 5'd7; d.rs = 2'b00;
    drive(d, 3'b000, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      drive(NOP, 3'b000, 1'b0);
      if (i == 3) begin
        checks++;
        if ({bus.RegWriteW, bus.RdW} !== {1'b1, 5'd7}) begin
          failures++;
          $display("FAIL latency_w3 got rw=%b rd=%0d exp rw=1 rd=7", bus.RegWriteW, bus.RdW);
        end
      end else if (i == 4) begin
        checks++;
        if (bus.RegWriteW !== 1'b0) begin
          failures++;
          $display("FAIL latency_one_cycle got rw=%b exp=0", bus.RegWriteW);
        end
      end
    end
  endtask

  task automatic test_load_use;
    d_t ld, use1, use2, alu;
    ld = NOP; ld.rw = 1'b1; ld.rs = 2'b01; ld.rd = 5'd3; ld.aluc = 3'b000;
    use1 = NOP; use1.rw = 1'b1; use1.rd = 5'd8; use1.rs1 = 5'd3; use1.rs2 = 5'd6;
    use1.aluc = 3'b110; use1.as = 1'b0;
    drive(ld, 3'b000, 1'b0);
    drive(use1, 3'b000, 1'b1);
    checks++; if ({bus.StallF, bus.StallD} !== 2'b11) begin failures++; $display("FAIL lu_stall got=%b exp=11", {bus.StallF, bus.StallD}); end
    checks++; if (bus.FlushD !== 1'b0) begin failures++; $display("FAIL lu_flushd got=%b exp=0", bus.FlushD); end
    drive(use1, 3'b000, 1'b0);
    checks++; if ({bus.StallF, bus.StallD} !== 2'b00) begin failures++; $display("FAIL lu_stall_once got=%b exp=00", {bus.StallF, bus.StallD}); end
    checks++; if (bus.ALUControlE !== 3'b000 || bus.ALUSrcE !== 1'b0) begin failures++; $display("FAIL lu_bubble_e got aluc=%b alusrc=%b exp 000/0", bus.ALUControlE, bus.ALUSrcE); end
    drive(NOP, 3'b000, 1'b0);
    checks++; if (bus.ALUControlE !== 3'b110) begin failures++; $display("FAIL lu_reissue_e got=%b exp=110", bus.ALUControlE); end
    checks++; if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0100) begin failures++; $display("FAIL lu_forward got A=%b B=%b exp 01/00", bus.ForwardAE, bus.ForwardBE); end
    // Rs2 dependence also stalls.
    ld.rd = 5'd12;
    use2 = NOP; use2.rw = 1'b1; use2.rd = 5'd13; use2.rs1 = 5'd1; use2.rs2 = 5'd12;
    drive(ld, 3'b000, 1'b0);
    drive(use2, 3'b000, 1'b1);
    checks++; if (bus.StallF !== 1'b1) begin failures++; $display("FAIL lu_rs2_stall got=%b exp=1", bus.StallF); end
    drive(use2, 3'b000, 1'b0);
    // Load into x0 never stalls.
    ld.rd = 5'd0;
    use2.rs1 = 5'd0; use2.rs2 = 5'd0;
    drive(ld, 3'b000, 1'b0);
    drive(use2, 3'b000, 1'b0);
    checks++; if ({bus.StallF, bus.StallD} !== 2'b00) begin failures++; $display("FAIL lu_x0_nostall got=%b exp=00", {bus.StallF, bus.StallD}); end
    // ALU producer is forwarded, not stalled.
    alu = NOP; alu.rw = 1'b1; alu.rd = 5'd3;
    drive(alu, 3'b000, 1'b0);
    drive(use1, 3'b000, 1'b0);
    checks++; if (bus.StallF !== 1'b0) begin failures++; $display("FAIL lu_alu_nostall got=%b exp=0", bus.StallF); end
    drive(NOP, 3'b000, 1'b0);
  endtask

  task automatic test_forward;
    logic [4:0] rdw_t [4] = '{5'd4, 5'd4, 5'd7, 5'd0};
    logic       rww_t [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0] rdm_t [4] = '{5'd4, 5'd4, 5'd4, 5'd0};
    logic       rwm_t [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] rs1_t [4] = '{5'd4, 5'd4, 5'd4, 5'd0};
    logic [4:0] rs2_t [4] = '{5'd4, 5'd0, 5'd7, 5'd0};
    logic [3:0] exp_t [4] = '{4'b1010, 4'b0100, 4'b1001, 4'b0000};
    d_t a, b, c;
    for (int i = 0; i < 4; i++) begin
      a = NOP; a.rw = rww_t[i]; a.rd = rdw_t[i];
      b = NOP; b.rw = rwm_t[i]; b.rd = rdm_t[i];
      c = NOP; c.rw = 1'b1; c.rd = 5'd9; c.rs1 = rs1_t[i]; c.rs2 = rs2_t[i];
      drive(a, 3'b000, 1'b0);
      drive(b, 3'b000, 1'b0);
      drive(c, 3'b000, 1'b0);
      drive(NOP, 3'b000, 1'b0);
      checks++;
      if ({bus.ForwardAE, bus.ForwardBE} !== exp_t[i]) begin
        failures++;
        $display("FAIL fwd_case%0d got A=%b B=%b exp A=%b B=%b", i, bus.ForwardAE,
                 bus.ForwardBE, exp_t[i][3:2], exp_t[i][1:0]);
      end
    end
  endtask

  task automatic test_branch;
    logic [2:0] f3_t [10] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101,
                              3'b110, 3'b110, 3'b111, 3'b010, 3'b011};
    logic [2:0] fl_t [10] = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b010,
                              3'b000, 3'b001, 3'b000, 3'b111, 3'b111};
    logic       ex_t [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                              1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    d_t br, fill;
    fill = NOP; fill.rw = 1'b1; fill.rd = 5'd11; fill.aluc = 3'b111; fill.as = 1'b1;
    fill.mw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      br = NOP; br.b = 1'b1; br.f3 = f3_t[i]; br.rs1 = 5'd1; br.rs2 = 5'd2;
      drive(br, 3'b000, 1'b0);
      drive(fill, fl_t[i], ex_t[i]);
      checks++;
      if ({bus.PCSrcE, bus.FlushD} !== {ex_t[i], ex_t[i]}) begin
        failures++;
        $display("FAIL br_case%0d f3=%b got pcsrc=%b flushd=%b exp=%b", i, f3_t[i],
                 bus.PCSrcE, bus.FlushD, ex_t[i]);
      end
      drive(NOP, 3'b000, 1'b0);
      checks++;
      if ({bus.ALUControlE, bus.ALUSrcE} !== (ex_t[i] ? 4'b0000 : 4'b1111)) begin
        failures++;
        $display("FAIL br_next_e%0d got aluc=%b alusrc=%b exp_bubble=%b", i,
                 bus.ALUControlE, bus.ALUSrcE, ex_t[i]);
      end
    end
  endtask

  task automatic test_jump_store;
    d_t jmp, st;
    jmp = NOP; jmp.j = 1'b1; jmp.rw = 1'b1; jmp.rd = 5'd1; jmp.rs = 2'b10;
    st = NOP; st.mw = 1'b1; st.rs1 = 5'd2; st.rs2 = 5'd3; st.as = 1'b1;
    drive(jmp, 3'b000, 1'b0);
    drive(st, 3'b000, 1'b1);
    checks++; if ({bus.PCSrcE, bus.FlushD} !== 2'b11) begin failures++; $display("FAIL jmp_pcsrc got pcsrc=%b flushd=%b exp 1/1", bus.PCSrcE, bus.FlushD); end
    for (int i = 0; i < 3; i++) begin
      drive(NOP, 3'b000, 1'b0);
      checks++;
      if (bus.MemWriteM !== 1'b0) begin
        failures++;
        $display("FAIL jmp_store_leak cycle%0d got=%b exp=0", i, bus.MemWriteM);
      end
    end
  endtask

  task automatic test_back_to_back;
    d_t d, prev;
    prev = NOP;
    drive(NOP, 3'b000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      d = NOP;
      d.rw   = 1'($urandom_range(0, 1));
      d.rs   = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
      d.mw   = 1'($urandom_range(0, 1));
      d.aluc = 3'($urandom_range(0, 7));
      d.as   = 1'($urandom_range(0, 1));
      d.rs1  = 5'($urandom_range(0, 31));
      d.rs2  = 5'($urandom_range(0, 31));
      d.rd   = 5'($urandom_range(0, 31));
      drive(d, 3'b000, 1'b0);
      checks++;
      if ({bus.ALUControlE, bus.ALUSrcE} !== {prev.aluc, prev.as}) begin
        failures++;
        $display("FAIL b2b_e%0d got aluc=%b alusrc=%b exp aluc=%b alusrc=%b", i,
                 bus.ALUControlE, bus.ALUSrcE, prev.aluc, prev.as);
      end
      prev = d;
    end
  endtask

  task automatic test_reset_midop;
    d_t d;
    d = NOP; d.rw = 1'b1; d.rd = 5'd20; d.mw = 1'b1;
    drive(d, 3'b000, 1'b0);
    drive(d, 3'b000, 1'b0);
    test_reset();
  endtask

  initial begin
    put(NOP, 3'b000);
    test_reset();
    test_latency();
    test_load_use();
    test_forward();
    test_branch();
    test_jump_store();
    test_back_to_back();
    test_reset_midop();
    test_latency();
    repeat (4) drive(NOP, 3'b000, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
